// File: rtl/mor1kx_spr_initiator_if.sv
// Bundle of the host request/response channels and the SPR bus seen by the
// SPR initiator. The master modport is the initiator itself; the slave
// modport is the host agent plus SPR responders on the other side.
interface mor1kx_spr_initiator_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [15:0] req_addr_i;
   logic [31:0] req_dat_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        spr_access_o;
   logic        spr_we_o;
   logic [15:0] spr_addr_o;
   logic [31:0] spr_dat_o;
   logic        spr_bus_ack_i;
   logic [31:0] spr_dat_i;

   modport master (
      input  req_valid_i, req_we_i, req_addr_i, req_dat_i, rsp_ready_i,
             spr_bus_ack_i, spr_dat_i,
      output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
             spr_access_o, spr_we_o, spr_addr_o, spr_dat_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_addr_i, req_dat_i, rsp_ready_i,
             spr_bus_ack_i, spr_dat_i,
      input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
             spr_access_o, spr_we_o, spr_addr_o, spr_dat_o
   );
endinterface

// File: rtl/mor1kx_spr_initiator.sv
// SPR bus initiator: accepts one host request at a time, holds it on the SPR
// bus until the responder acks, then returns read data on a valid/ready
// response channel.
// Optional feature macro: MOR1KX_SPR_INITIATOR_TIMEOUT_EN adds an 8-bit
// access timeout that aborts the transaction with rsp_err_o after
// TIMEOUT_CYCLES unacknowledged ACCESS cycles. Without it, ACCESS waits
// for the ack indefinitely and rsp_err_o is constant 0.
module mor1kx_spr_initiator #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                     clk,
   input logic                     rst_n,
   mor1kx_spr_initiator_if.master  spr_if
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic        r_we;
   logic [15:0] r_addr;
   logic [31:0] r_dat;
   logic [31:0] r_rspDat;
   logic        w_accept;
   logic        w_ack;
   logic        w_rspLoad;
   logic [31:0] w_rspDat;

   assign w_accept = (r_state == IDLE) && spr_if.req_valid_i;
   assign w_ack    = (r_state == ACCESS) && spr_if.spr_bus_ack_i;

`ifdef MOR1KX_SPR_INITIATOR_TIMEOUT_EN
   logic [7:0] r_count;
   logic [7:0] w_countNext;
   logic       w_timeout;
   logic       r_rspErr;

   assign w_timeout = (r_count == 8'(TIMEOUT_CYCLES - 1));

   // Timeout counter: cleared on accept, counts unacknowledged ACCESS cycles
   always_comb begin
      w_countNext = r_count;
      if (w_accept) begin
         w_countNext = 8'd0;
      end else if ((r_state == ACCESS) && !w_ack) begin
         w_countNext = r_count + 8'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 8'd0;
      end else begin
         r_count <= w_countNext;
      end
   end

   // Error flag: a response loaded without an ack can only be a timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rspErr <= 1'b0;
      end else if (w_rspLoad) begin
         r_rspErr <= !w_ack;
      end
   end

   assign spr_if.rsp_err_o = r_rspErr;
`else
   assign spr_if.rsp_err_o = 1'b0;
`endif

   // Next-state and response-load decode; an ack always beats the timeout
   always_comb begin
      w_stateNext = r_state;
      w_rspLoad   = 1'b0;
      w_rspDat    = 32'h0;
      case (r_state)
         IDLE: begin
            if (spr_if.req_valid_i) begin
               w_stateNext = ACCESS;
            end
         end
         ACCESS: begin
            if (w_ack) begin
               w_rspLoad   = 1'b1;
               w_rspDat    = r_we ? 32'h0 : spr_if.spr_dat_i;
               w_stateNext = RESP;
            end
`ifdef MOR1KX_SPR_INITIATOR_TIMEOUT_EN
            else if (w_timeout) begin
               w_rspLoad   = 1'b1;
               w_rspDat    = 32'h0;
               w_stateNext = RESP;
            end
`endif
         end
         RESP: begin
            if (spr_if.rsp_ready_i) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // FSM state register; reset drops ACCESS (and spr_access_o) immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Request capture so the SPR bus stays stable for the whole access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we   <= 1'b0;
         r_addr <= 16'h0;
         r_dat  <= 32'h0;
      end else if (w_accept) begin
         r_we   <= spr_if.req_we_i;
         r_addr <= spr_if.req_addr_i;
         r_dat  <= spr_if.req_dat_i;
      end
   end

   // Response data register, held through RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rspDat <= 32'h0;
      end else if (w_rspLoad) begin
         r_rspDat <= w_rspDat;
      end
   end

   // SPR bus fields are zero outside ACCESS so no stray write can be decoded
   assign spr_if.req_ready_o  = (r_state == IDLE) && rst_n;
   assign spr_if.spr_access_o = (r_state == ACCESS);
   assign spr_if.spr_we_o     = (r_state == ACCESS) ? r_we   : 1'b0;
   assign spr_if.spr_addr_o   = (r_state == ACCESS) ? r_addr : 16'h0;
   assign spr_if.spr_dat_o    = (r_state == ACCESS) ? r_dat  : 32'h0;
   assign spr_if.rsp_valid_o  = (r_state == RESP);
   assign spr_if.rsp_dat_o    = r_rspDat;

endmodule
